// File: rtl/tick_timer.sv
// tick_timer: counts upstream tick pulses down from a captured load value.
// States IDLE / RUN / DONE. Priority on each edge: stop > start > tick.
// Optional macro TICK_TIMER_EXPCNT_EN builds a saturating 8-bit expiry counter;
// when it is undefined, o_exp_count is tied to 0 and no counter is built.
module tick_timer #(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_tick,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic [N-1:0] i_load_val,
  input  logic         i_periodic,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_expired,
  output logic [N-1:0] o_remaining,
  output logic [7:0]   o_exp_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [N-1:0] load_q;
  logic         periodic_q;
  logic         start_ok;
  logic         expire_now;

  // A start is only accepted with a non-zero load; an expiry is the final tick of a period
  always_comb begin
    start_ok   = i_start && (i_load_val != '0);
    expire_now = !i_stop && !start_ok && (state == RUN) && i_tick
                 && (o_remaining == N'(1));
  end

  // Control FSM with registered status outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      load_q      <= '0;
      periodic_q  <= 1'b0;
      o_remaining <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_expired   <= 1'b0;
    end else begin
      o_expired <= 1'b0;
      if (i_stop) begin
        state       <= IDLE;
        o_remaining <= '0;
        o_busy      <= 1'b0;
        o_done      <= 1'b0;
      end else if (start_ok) begin
        state       <= RUN;
        load_q      <= i_load_val;
        periodic_q  <= i_periodic;
        o_remaining <= i_load_val;
        o_busy      <= 1'b1;
        o_done      <= 1'b0;
      end else if ((state == RUN) && i_tick) begin
        if (expire_now) begin
          o_expired <= 1'b1;
          if (periodic_q) begin
            o_remaining <= load_q;
          end else begin
            state       <= DONE;
            o_remaining <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
          end
        end else begin
          o_remaining <= o_remaining - N'(1);
        end
      end
    end
  end

`ifdef TICK_TIMER_EXPCNT_EN
  // Saturating expiry counter, cleared on stop and on every accepted start
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_exp_count <= '0;
    end else if (i_stop || start_ok) begin
      o_exp_count <= '0;
    end else if (expire_now && (o_exp_count != 8'hFF)) begin
      o_exp_count <= o_exp_count + 8'd1;
    end
  end
`else
  assign o_exp_count = '0;
`endif

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter N, default 8, width of load value and remaining-tick count.
REQ-002 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-003 i_reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_tick  in  1  one-cycle tick pulse from the upstream mod-k roll-over counter; each high cycle is one tick.
REQ-005 i_start  in  1  start/restart request, sampled each edge.
REQ-006 i_stop  in  1  abort request, sampled each edge.
REQ-007 i_load_val  in  N  tick count per period, captured on accepted start.
REQ-008 i_periodic  in  1  1 = auto-reload after expiry, 0 = one-shot; captured on accepted start.
REQ-009 o_busy  out  1  high while in RUN.
REQ-010 o_done  out  1  high while in DONE.
REQ-011 o_expired  out  1  registered one-cycle pulse per expiry.
REQ-012 o_remaining  out  N  ticks left in the current period.
REQ-013 o_exp_count  out  8  expiry counter (see Configuration).

Function
REQ-014 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 Priority each edge SHALL be: i_stop > i_start > i_tick.
REQ-016 i_stop in any state SHALL go to IDLE, clear o_remaining to 0, and suppress o_expired for that edge.
REQ-017 i_start with i_load_val != 0 in any state SHALL capture i_load_val and i_periodic, set o_remaining = i_load_val, and enter RUN; a same-cycle i_tick SHALL be ignored.
REQ-018 i_start with i_load_val == 0 SHALL be ignored; state and outputs stay unchanged.
REQ-019 In RUN, i_tick with o_remaining > 1 SHALL decrement o_remaining by 1.
REQ-020 In RUN, i_tick with o_remaining == 1 is an expiry: o_expired SHALL be high for exactly the next cycle.
REQ-021 On expiry with captured periodic = 1, o_remaining SHALL reload to the captured load value and state SHALL stay RUN.
REQ-022 On expiry with captured periodic = 0, o_remaining SHALL become 0 and state SHALL go to DONE.
REQ-023 i_tick in IDLE or DONE SHALL have no effect.
REQ-024 DONE SHALL persist until i_start (valid) or i_stop.
REQ-025 Captured load value 1 with periodic = 1 SHALL give one expiry pulse per tick, including back-to-back ticks.
REQ-026 i_load_val and i_periodic changes while in RUN SHALL have no effect until the next accepted start.

Reset
REQ-027 i_reset_n low SHALL immediately force IDLE, o_busy = 0, o_done = 0, o_expired = 0, o_remaining = 0, o_exp_count = 0, captured load = 0, captured periodic = 0.
REQ-028 Reset asserted mid-RUN SHALL discard the period with no o_expired pulse; operation resumes only on a new i_start after deassertion.

Configuration
REQ-029 Macro TICK_TIMER_EXPCNT_EN defined: o_exp_count SHALL increment on every expiry, saturate at 255, and clear to 0 on every accepted start and on i_stop.
REQ-030 Macro TICK_TIMER_EXPCNT_EN undefined: port o_exp_count SHALL remain present and be tied to 0, and no counter logic SHALL be built.

Verification
REQ-031 Reset, then start with load 3, periodic 0, then ticks on cycles 2, 5 and 6 -> o_remaining steps 3, 2, 1, 0; o_expired high one cycle after the cycle-6 tick; o_done high, o_busy low.
REQ-032 Start with load 2, periodic 1, then 6 consecutive ticks -> o_expired pulses after ticks 2, 4 and 6; o_remaining reloads to 2; with macro defined, o_exp_count = 3.
REQ-033 In RUN with remaining 1, assert i_stop and i_tick in the same cycle -> IDLE, o_remaining 0, no o_expired; i_start with load 0 afterwards -> stays IDLE.
REQ-034 In RUN with remaining 4, assert i_start (load 5) and i_tick in the same cycle -> o_remaining 5, no decrement.
REQ-035 Pull i_reset_n low mid-RUN, asynchronously to the clock edge -> all outputs 0 immediately; ticks after release -> no effect until i_start.
REQ-036 With macro defined, periodic load 1 and 300 ticks -> o_exp_count saturates at 255; without macro -> o_exp_count stays 0 throughout.
